// File: rtl/wb_write_port_pkg.sv
// wb_write_port_pkg
// Shared definitions for the writeback write-port sequencer:
//   REG_W     - register index width
//   ZERO, RA  - architectural register indices for $zero and $ra
//   aux_entry_t - one queued auxiliary write {rd, data}
package wb_write_port_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO = 5'd0;
    localparam logic [REG_W-1:0] RA   = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [31:0]      data;
    } aux_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// wb_aux_fifo
// Small FIFO holding auxiliary (mult/div, load-miss) register writes in
// acceptance order.
// Parameters: DEPTH - number of entries (power of two, >= 2)
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   push, push_entry    - write push_entry at the tail
//   pop                 - advance the head (caller only pops when non-empty)
//   head_entry          - current head, readable in the same cycle as pop
//   count, full, empty  - occupancy, all from registered state
// Push and pop in the same cycle leave count unchanged at any occupancy.
module wb_aux_fifo
    import wb_write_port_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  aux_entry_t                 push_entry,
    input  logic                       pop,
    output aux_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    aux_entry_t         mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = mem_reg[rd_ptr_reg];
    assign count      = count_reg;
    assign full       = (count_reg == DEPTH_C);
    assign empty      = (count_reg == '0);

endmodule

// File: rtl/wb_write_port.sv
// wb_write_port
// Owns the single register-file write port. Each cycle it registers one
// write chosen by priority: pipeline writeback, then the aux FIFO head, then
// a same-cycle aux result bypassing an empty FIFO. Aux results that are
// accepted but not emitted are queued in wb_aux_fifo.
// Optional feature macro: WB_SCOREBOARD_EN - when defined, pending_mask
// tracks issued long-latency destinations; otherwise it is tied to 0 and
// aux_issue/aux_issue_rd are ignored.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data/wb_jal       - pipeline writeback request
//   aux_valid/aux_ready/aux_rd/aux_data - aux result handshake
//   aux_issue/aux_issue_rd              - scoreboard set on long-latency issue
//   rf_rd/rf_write_data/rf_reg_write/rf_jal - registered write to the RF
//   pending_mask                        - outstanding aux destinations
//   stall_req                           - FIFO full, pipeline should bubble
module wb_write_port
    import wb_write_port_pkg::*;
#(
    parameter int AUX_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [31:0]      wb_data,
    input  logic             wb_jal,
    input  logic             aux_valid,
    output logic             aux_ready,
    input  logic [REG_W-1:0] aux_rd,
    input  logic [31:0]      aux_data,
    input  logic             aux_issue,
    input  logic [REG_W-1:0] aux_issue_rd,
    output logic [REG_W-1:0] rf_rd,
    output logic [31:0]      rf_write_data,
    output logic             rf_reg_write,
    output logic             rf_jal,
    output logic [31:0]      pending_mask,
    output logic             stall_req
);

    localparam int CNT_W = $clog2(AUX_DEPTH) + 1;

    aux_entry_t        head_entry;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              aux_fire;
    logic              fifo_push;
    logic              fifo_pop;

    logic [REG_W-1:0]  rf_rd_reg,   rf_rd_next;
    logic [31:0]       rf_data_reg, rf_data_next;
    logic              rf_we_reg,   rf_we_next;
    logic              rf_jal_reg,  rf_jal_next;
    logic              aux_emit;
    logic [REG_W-1:0]  aux_emit_rd;

    // Ready looks only at registered occupancy, never at this cycle's pop.
    assign aux_ready = ~reset & ~fifo_full;
    assign aux_fire  = aux_valid & aux_ready;
    assign stall_req = (fifo_count == CNT_W'(AUX_DEPTH));

    // Head leaves whenever the pipeline is idle; a fresh aux result skips
    // the FIFO only when nothing older is queued, preserving order.
    assign fifo_pop  = ~wb_valid & ~fifo_empty;
    assign fifo_push = aux_fire & ~(~wb_valid & fifo_empty);

    wb_aux_fifo #(
        .DEPTH (AUX_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry ({aux_rd, aux_data}),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        rf_we_next   = 1'b0;
        rf_jal_next  = 1'b0;
        rf_rd_next   = rf_rd_reg;
        rf_data_next = rf_data_reg;
        aux_emit     = 1'b0;
        aux_emit_rd  = ZERO;
        if (wb_valid) begin
            rf_jal_next  = wb_jal;
            rf_rd_next   = wb_jal ? RA : wb_rd;
            rf_data_next = wb_data;
            rf_we_next   = wb_jal | (wb_rd != ZERO);
        end else if (!fifo_empty) begin
            rf_rd_next   = head_entry.rd;
            rf_data_next = head_entry.data;
            rf_we_next   = (head_entry.rd != ZERO);
            aux_emit     = 1'b1;
            aux_emit_rd  = head_entry.rd;
        end else if (aux_fire) begin
            rf_rd_next   = aux_rd;
            rf_data_next = aux_data;
            rf_we_next   = (aux_rd != ZERO);
            aux_emit     = 1'b1;
            aux_emit_rd  = aux_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_rd_reg   <= ZERO;
            rf_data_reg <= '0;
            rf_we_reg   <= 1'b0;
            rf_jal_reg  <= 1'b0;
        end else begin
            rf_rd_reg   <= rf_rd_next;
            rf_data_reg <= rf_data_next;
            rf_we_reg   <= rf_we_next;
            rf_jal_reg  <= rf_jal_next;
        end
    end

    assign rf_rd         = rf_rd_reg;
    assign rf_write_data = rf_data_reg;
    assign rf_reg_write  = rf_we_reg;
    assign rf_jal        = rf_jal_reg;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending_reg;

    // One flop per register; $zero can never be pending. Set beats clear.
    for (genvar gi = 0; gi < 32; gi++) begin : g_pending
        if (gi == 0) begin : g_zero
            always_ff @(posedge clk) begin
                pending_reg[gi] <= 1'b0;
            end
        end else begin : g_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    pending_reg[gi] <= 1'b0;
                end else if (aux_issue && (aux_issue_rd == REG_W'(gi))) begin
                    pending_reg[gi] <= 1'b1;
                end else if (aux_emit && (aux_emit_rd == REG_W'(gi))) begin
                    pending_reg[gi] <= 1'b0;
                end
            end
        end
    end

    assign pending_mask = pending_reg;
`else
    logic unused_scoreboard;
    assign unused_scoreboard = ^{aux_issue, aux_issue_rd, aux_emit, aux_emit_rd};
    assign pending_mask      = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// tb_wb_write_port
// Randomized and directed stimulus for wb_write_port, checked every cycle
// against a queue-based reference model of the write-port rules.
module tb_wb_write_port;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_jal;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic        aux_issue;
    logic [4:0]  aux_issue_rd;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;
    logic        rf_jal;
    logic [31:0] pending_mask;
    logic        stall_req;

    wb_write_port #(.AUX_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_jal        (wb_jal),
        .aux_valid     (aux_valid),
        .aux_ready     (aux_ready),
        .aux_rd        (aux_rd),
        .aux_data      (aux_data),
        .aux_issue     (aux_issue),
        .aux_issue_rd  (aux_issue_rd),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .rf_jal        (rf_jal),
        .pending_mask  (pending_mask),
        .stall_req     (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_mask;
    int          n_checks;
    int          n_errors;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check ready/stall, clock, advance the
    // model, then check the registered write and the mask.
    task automatic step(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic wj, input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic iv, input logic [4:0] ird,
                        input logic rs);
        logic        m_ready;
        logic        fire;
        logic        has_write;
        logic        e_we;
        logic        e_jal;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        ent_t        ent;
        wb_valid = wv; wb_rd = wrd; wb_data = wd; wb_jal = wj;
        aux_valid = av; aux_rd = ard; aux_data = ad;
        aux_issue = iv; aux_issue_rd = ird; reset = rs;
        #1;
        m_ready = !rs && (m_q.size() < DEPTH);
        check("aux_ready", {31'd0, aux_ready}, {31'd0, m_ready});
        if (!rs) check("stall_req", {31'd0, stall_req}, {31'd0, m_q.size() == DEPTH});
        fire = av && m_ready;
        @(posedge clk);
        has_write = 1'b1;
        e_we = 1'b0; e_jal = 1'b0; e_rd = 5'd0; e_data = 32'd0;
        if (rs) begin
            m_q.delete();
            m_mask = 32'd0;
        end else begin
            if (fire) m_q.push_back('{rd: ard, data: ad});
            if (wv) begin
                e_jal  = wj;
                e_rd   = wj ? 5'd31 : wrd;
                e_data = wd;
                e_we   = !(!wj && wrd == 5'd0);
            end else if (m_q.size() > 0) begin
                ent    = m_q.pop_front();
                e_rd   = ent.rd;
                e_data = ent.data;
                e_we   = (ent.rd != 5'd0);
`ifdef WB_SCOREBOARD_EN
                m_mask[ent.rd] = 1'b0;
`endif
            end else begin
                has_write = 1'b0;
            end
`ifdef WB_SCOREBOARD_EN
            if (iv && ird != 5'd0) m_mask[ird] = 1'b1;
`endif
        end
        #1;
        check("rf_reg_write", {31'd0, rf_reg_write}, {31'd0, e_we});
        check("rf_jal", {31'd0, rf_jal}, {31'd0, e_jal});
        if (has_write) begin
            check("rf_rd", {27'd0, rf_rd}, {27'd0, e_rd});
            check("rf_write_data", rf_write_data, e_data);
        end
        check("pending_mask", pending_mask, m_mask);
        $display("cyc %0d rst=%0b wb=%0b aux=%0b/%0b -> we=%0b jal=%0b rd=%0d data=0x%08h mask=0x%08h q=%0d",
                 cyc, rs, wv, av, fire, rf_reg_write, rf_jal, rf_rd, rf_write_data,
                 pending_mask, m_q.size());
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        m_mask = 32'd0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // Pipeline write and jal link
        step(1, 8, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Contention: wb every cycle, aux fills FIFO, third held off
        step(1, 1, 32'h11, 0, 1, 9, 32'hA, 0, 0, 0);
        step(1, 2, 32'h22, 0, 1, 10, 32'hB, 0, 0, 0);
        step(1, 3, 32'h33, 0, 1, 11, 32'hC, 0, 0, 0);
        step(1, 4, 32'h44, 0, 1, 11, 32'hC, 0, 0, 0);
        step(0, 0, 0, 0, 1, 11, 32'hC, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Scoreboard set, clear by emit, same-cycle set wins
        step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        step(0, 0, 0, 0, 1, 12, 32'h77, 0, 0, 0);
        step(0, 0, 0, 0, 1, 12, 32'h78, 1, 12, 0);
        step(0, 0, 0, 0, 1, 12, 32'h79, 0, 0, 0);

        // Zero register through the FIFO
        step(1, 5, 32'h55, 0, 1, 0, 32'h99, 0, 0, 0);
        idle();

        // Reset with a full FIFO and pending $9/$10
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
        step(1, 6, 32'h66, 0, 1, 9, 32'h9, 0, 0, 0);
        step(1, 7, 32'h67, 0, 1, 10, 32'h10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r1;
            logic [4:0] r2;
            logic [4:0] r3;
            r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r2 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r3 = 5'($urandom);
            step($urandom_range(0, 9) < 5, r1, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6, r2, $urandom,
                 $urandom_range(0, 3) == 0, r3, $urandom_range(0, 79) == 0);
        end
        idle();
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
